// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master / one-slave round-robin arbiter for a valid/ready memory bus.
// Master 0 (CPU) and master 1 (DMA/debug) share one downstream slave port. The winning
// request is captured, presented to the slave, and the response is returned registered.
// Optional build macro MEM_ARBITER_TIMEOUT_EN adds a bus-timeout watchdog with a sticky error flag.

package mem_arbiter_pkg;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned CNT_W  = 16;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } mem_req_t;
endpackage

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter logic [CNT_W-1:0]  TIMEOUT_CYCLES = 16'd1024,
   parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = 32'hdeadbeef
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_valid,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [STRB_W-1:0] m0_wstrb,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ready,
   input  logic              m1_valid,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [STRB_W-1:0] m1_wstrb,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ready,
   output logic              s_valid,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   output logic [STRB_W-1:0] s_wstrb,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_ready,
   output logic              error
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GRANT0 = 3'd1,
      GRANT1 = 3'd2,
      RESP0  = 3'd3,
      RESP1  = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic              last_q, last_d;          // 1: master 1 was granted last
   mem_req_t          req_q, req_d;
   logic              s_valid_q, s_valid_d;
   logic              m0_ready_q, m0_ready_d;
   logic              m1_ready_q, m1_ready_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

`ifdef MEM_ARBITER_TIMEOUT_EN
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              error_q, error_d;
   logic              timeout_c;

   // Watchdog expiry: last allowed wait cycle reached without a slave response
   assign timeout_c = (cnt_q == (TIMEOUT_CYCLES - CNT_W'(1)));
`endif

   // Arbitration, capture and response sequencing; all outputs derive from next state
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      req_d      = req_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
`ifdef MEM_ARBITER_TIMEOUT_EN
      cnt_d      = cnt_q;
      error_d    = error_q;
`endif

      case (state_q)
         IDLE: begin
`ifdef MEM_ARBITER_TIMEOUT_EN
            cnt_d = '0;
`endif
            // m0 wins when alone or when m1 held the previous grant
            if (m0_valid && (!m1_valid || last_q)) begin
               state_d     = GRANT0;
               last_d      = 1'b0;
               req_d.addr  = m0_addr;
               req_d.wdata = m0_wdata;
               req_d.wstrb = m0_wstrb;
            end else if (m1_valid) begin
               state_d     = GRANT1;
               last_d      = 1'b1;
               req_d.addr  = m1_addr;
               req_d.wdata = m1_wdata;
               req_d.wstrb = m1_wstrb;
            end
         end
         GRANT0: begin
            if (s_ready) begin
               m0_rdata_d = s_rdata;
               state_d    = RESP0;
            end
`ifdef MEM_ARBITER_TIMEOUT_EN
            else if (timeout_c) begin
               m0_rdata_d = TIMEOUT_RDATA;
               state_d    = RESP0;
               error_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         GRANT1: begin
            if (s_ready) begin
               m1_rdata_d = s_rdata;
               state_d    = RESP1;
            end
`ifdef MEM_ARBITER_TIMEOUT_EN
            else if (timeout_c) begin
               m1_rdata_d = TIMEOUT_RDATA;
               state_d    = RESP1;
               error_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         RESP0, RESP1: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      s_valid_d  = (state_d == GRANT0) || (state_d == GRANT1);
      m0_ready_d = (state_d == RESP0);
      m1_ready_d = (state_d == RESP1);
   end

   // State and output registers; reset aborts any access in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         req_q      <= '0;
         s_valid_q  <= 1'b0;
         m0_ready_q <= 1'b0;
         m1_ready_q <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         req_q      <= req_d;
         s_valid_q  <= s_valid_d;
         m0_ready_q <= m0_ready_d;
         m1_ready_q <= m1_ready_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
      end
   end

`ifdef MEM_ARBITER_TIMEOUT_EN
   // Watchdog counter and sticky timeout flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         error_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         error_q <= error_d;
      end
   end

   assign error = error_q;
`else
   logic unused_timeout_cfg;

   // Timeout parameters have no effect without the watchdog
   assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_RDATA};
   assign error              = 1'b0;
`endif

   assign s_valid  = s_valid_q;
   assign s_addr   = req_q.addr;
   assign s_wdata  = req_q.wdata;
   assign s_wstrb  = req_q.wstrb;
   assign m0_ready = m0_ready_q;
   assign m0_rdata = m0_rdata_q;
   assign m1_ready = m1_ready_q;
   assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized two-master traffic
// checked against a transaction-level arbitration model. Timeout scenarios run only when
// MEM_ARBITER_TIMEOUT_EN is defined.

module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam logic [15:0] TO_CYC  = 16'd8;
   localparam logic [31:0] TO_DATA = 32'hdeadbeef;
   localparam int          N_TXN   = 40;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        m0_valid = 1'b0, m1_valid = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
   logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ready, m1_ready;
   logic        s_valid, s_ready, error;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;

   int checks = 0;
   int failures = 0;

   // Behavioural slave: responds after slv_wait wait states, or never
   int          slv_wait = 0;
   int          slv_cnt;
   logic [31:0] slv_rdata = '0;
   bit          slv_never = 1'b0;

   mem_req_t req0 [N_TXN];
   mem_req_t req1 [N_TXN];

   assign s_ready = s_valid && !slv_never && (slv_cnt == slv_wait);
   assign s_rdata = slv_rdata;

   always #5 clk = ~clk;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)                 slv_cnt <= 0;
      else if (s_valid && !s_ready) slv_cnt <= slv_cnt + 1;
      else                          slv_cnt <= 0;
   end

   mem_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .TIMEOUT_RDATA(TO_DATA)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_rdata(m0_rdata), .m0_ready(m0_ready),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_rdata(m1_rdata), .m1_ready(m1_ready),
      .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_rdata(s_rdata), .s_ready(s_ready), .error(error)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset;
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      reset_n  = 1'b0;
      tick();
      reset_n  = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (s_valid !== 1'b0) begin failures++; $display("FAIL reset_s_valid got=%b exp=0", s_valid); end
      checks++;
      if ({s_addr, s_wdata, s_wstrb} !== 68'h0) begin
         failures++; $display("FAIL reset_s_bus got=%h exp=0", {s_addr, s_wdata, s_wstrb});
      end
      checks++;
      if ({m0_ready, m1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {m0_ready, m1_ready}); end
      checks++;
      if ({m0_rdata, m1_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {m0_rdata, m1_rdata}); end
      checks++;
      if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
      reset_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_single_read;
      slv_wait  = 0;
      slv_rdata = 32'h12345678;
      m0_valid  = 1'b1;
      m0_addr   = 32'h41000000;
      m0_wdata  = $urandom;
      m0_wstrb  = 4'h0;
      tick();
      checks++;
      if ({s_valid, s_addr, s_wstrb} !== {1'b1, 32'h41000000, 4'h0}) begin
         failures++; $display("FAIL read_grant got v=%b a=%h s=%h exp v=1 a=41000000 s=0", s_valid, s_addr, s_wstrb);
      end
      tick();
      checks++;
      if ({m0_ready, m0_rdata} !== {1'b1, 32'h12345678}) begin
         failures++; $display("FAIL read_resp got rdy=%b data=%h exp rdy=1 data=12345678", m0_ready, m0_rdata);
      end
      checks++;
      if ({m1_ready, s_valid} !== 2'b00) begin
         failures++; $display("FAIL read_other got m1_ready=%b s_valid=%b exp 0 0", m1_ready, s_valid);
      end
      m0_valid = 1'b0;
      tick();
      checks++;
      if ({m0_ready, m0_rdata, m1_rdata} !== {1'b0, 32'h12345678, 32'h0}) begin
         failures++; $display("FAIL read_pulse got rdy=%b d0=%h d1=%h exp rdy=0 d0=12345678 d1=0", m0_ready, m0_rdata, m1_rdata);
      end
      tick();
   endtask

   task automatic test_contention;
      int   grants;
      bit   prev_sv;
      bit   done;
      logic [3:0] exp_tag;
      grants  = 0;
      prev_sv = 1'b0;
      done    = 1'b0;
      slv_wait = 0;
      pulse_reset();
      m0_addr = 32'h10000000; m0_wstrb = 4'h0; m0_valid = 1'b1;
      m1_addr = 32'h20000000; m1_wstrb = 4'h0; m1_valid = 1'b1;
      for (int c = 0; c < 100 && !done; c++) begin
         tick();
         if (s_valid && !prev_sv) begin
            exp_tag = (grants % 2 == 0) ? 4'h1 : 4'h2;
            checks++;
            if (s_addr[31:28] !== exp_tag) begin
               failures++; $display("FAIL contention_order grant=%0d got=%h exp=%h", grants, s_addr[31:28], exp_tag);
            end
            grants++;
         end
         prev_sv = s_valid;
         if (m0_ready) m0_addr = m0_addr + 32'd1;
         if (m1_ready) begin
            m1_addr = m1_addr + 32'd1;
            if (grants >= 8) done = 1'b1;
         end
      end
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      checks++;
      if (grants !== 8) begin failures++; $display("FAIL contention_count got=%0d exp=8", grants); end
      repeat (2) tick();
   endtask

   task automatic test_write_wait;
      int          sv_cycles;
      bit          got;
      logic [31:0] exp_rd;
      sv_cycles = 0;
      got       = 1'b0;
      exp_rd    = '0;
      slv_wait  = 5;
      slv_rdata = $urandom;
      m1_valid  = 1'b1;
      m1_addr   = 32'h43000004;
      m1_wdata  = 32'hcafef00d;
      m1_wstrb  = 4'hf;
      tick();
      for (int c = 0; c < 20 && !got; c++) begin
         if (s_valid) begin
            sv_cycles++;
            checks++;
            if ({s_addr, s_wdata, s_wstrb} !== {32'h43000004, 32'hcafef00d, 4'hf}) begin
               failures++; $display("FAIL write_stable got a=%h d=%h s=%h exp a=43000004 d=cafef00d s=f", s_addr, s_wdata, s_wstrb);
            end
            m1_wdata = $urandom;
            m1_addr  = $urandom;
         end
         if (s_valid && s_ready) begin
            exp_rd = slv_rdata;
            tick();
            checks++;
            if ({m1_ready, m0_ready, m1_rdata} !== {1'b1, 1'b0, exp_rd}) begin
               failures++; $display("FAIL write_resp got r1=%b r0=%b d=%h exp r1=1 r0=0 d=%h", m1_ready, m0_ready, m1_rdata, exp_rd);
            end
            m1_valid = 1'b0;
            tick();
            checks++;
            if (m1_ready !== 1'b0) begin failures++; $display("FAIL write_pulse got=%b exp=0", m1_ready); end
            got = 1'b1;
         end else begin
            tick();
         end
      end
      checks++;
      if ({got, sv_cycles} !== {1'b1, 32'd6}) begin
         failures++; $display("FAIL write_wait got done=%b cycles=%0d exp done=1 cycles=6", got, sv_cycles);
      end
      tick();
   endtask

   task automatic drive_master(input int m, input int n);
      for (int i = 0; i < n; i++) begin
         int gap;
         bit seen;
         gap  = $urandom_range(0, 3);
         seen = 1'b0;
         repeat (gap) tick();
         if (m == 0) begin
            m0_valid = 1'b1; m0_addr = req0[i].addr; m0_wdata = req0[i].wdata; m0_wstrb = req0[i].wstrb;
         end else begin
            m1_valid = 1'b1; m1_addr = req1[i].addr; m1_wdata = req1[i].wdata; m1_wstrb = req1[i].wstrb;
         end
         for (int c = 0; c < 200 && !seen; c++) begin
            tick();
            seen = (m == 0) ? m0_ready : m1_ready;
         end
         checks++;
         if (seen !== 1'b1) begin failures++; $display("FAIL random_served master=%0d txn=%0d got no ready", m, i); end
         if (m == 0) m0_valid = 1'b0;
         else        m1_valid = 1'b0;
      end
   endtask

   task automatic monitor_random(input int n);
      bit          prev_v0, prev_v1, prev_sv, prev_idle, last_m1, resp_due, grant_now, grant_exp;
      int          owner, served0, served1, cyc;
      logic [31:0] exp_rd;
      mem_req_t    cur;
      prev_v0 = 0; prev_v1 = 0; prev_sv = 0; prev_idle = 0; last_m1 = 1; resp_due = 0;
      owner = 0; served0 = 0; served1 = 0; cyc = 0; exp_rd = '0; cur = '0;
      while ((served0 < n || served1 < n) && cyc < 6000) begin
         @(posedge clk);
         #2;
         cyc++;
         if (resp_due) begin
            checks++;
            if ({m1_ready, m0_ready} !== ((owner == 0) ? 2'b01 : 2'b10) ||
                ((owner == 0) ? m0_rdata : m1_rdata) !== exp_rd) begin
               failures++;
               $display("FAIL random_resp owner=%0d got r1r0=%b d0=%h d1=%h exp_data=%h", owner, {m1_ready, m0_ready}, m0_rdata, m1_rdata, exp_rd);
            end
            if (owner == 0) served0++;
            else            served1++;
            resp_due  = 1'b0;
            slv_wait  = $urandom_range(0, 3);
            slv_rdata = $urandom;
         end else begin
            checks++;
            if ({m1_ready, m0_ready} !== 2'b00) begin
               failures++; $display("FAIL random_spurious_ready got=%b exp=00", {m1_ready, m0_ready});
            end
         end
         grant_now = s_valid && !prev_sv;
         grant_exp = prev_idle && (prev_v0 || prev_v1);
         checks++;
         if (grant_now !== grant_exp) begin
            failures++; $display("FAIL random_grant_timing cyc=%0d got=%b exp=%b", cyc, grant_now, grant_exp);
         end
         if (grant_now) begin
            if (prev_v0 && prev_v1) owner = last_m1 ? 0 : 1;
            else                    owner = prev_v0 ? 0 : 1;
            last_m1 = (owner == 1);
            if (owner == 0 && served0 < n)      cur = req0[served0];
            else if (owner == 1 && served1 < n) cur = req1[served1];
         end
         if (s_valid) begin
            checks++;
            if ({s_addr, s_wdata, s_wstrb} !== cur) begin
               failures++; $display("FAIL random_payload owner=%0d got=%h exp=%h", owner, {s_addr, s_wdata, s_wstrb}, cur);
            end
            if (s_ready) begin
               resp_due = 1'b1;
               exp_rd   = slv_rdata;
            end
         end
         prev_v0   = m0_valid;
         prev_v1   = m1_valid;
         prev_sv   = s_valid;
         prev_idle = !s_valid && !m0_ready && !m1_ready;
      end
      checks++;
      if (served0 != n || served1 != n) begin
         failures++; $display("FAIL random_completion got m0=%0d m1=%0d exp=%0d each", served0, served1, n);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < N_TXN; i++) begin
         req0[i] = '{addr: $urandom, wdata: $urandom, wstrb: 4'($urandom_range(0, 15))};
         req1[i] = '{addr: $urandom, wdata: $urandom, wstrb: 4'($urandom_range(0, 15))};
      end
      slv_never = 1'b0;
      slv_wait  = $urandom_range(0, 3);
      slv_rdata = $urandom;
      pulse_reset();
      fork
         drive_master(0, N_TXN);
         drive_master(1, N_TXN);
         monitor_random(N_TXN);
      join
      checks++;
      if (error !== 1'b0) begin failures++; $display("FAIL random_error got=%b exp=0", error); end
      repeat (2) tick();
   endtask

`ifdef MEM_ARBITER_TIMEOUT_EN
   task automatic test_timeout_race;
      int          sv;
      logic [31:0] exp_rd;
      sv = 0;
      pulse_reset();
      slv_never = 1'b0;
      slv_wait  = 7;
      slv_rdata = $urandom;
      exp_rd    = slv_rdata;
      m1_valid = 1'b1; m1_addr = $urandom; m1_wstrb = 4'h0;
      tick();
      while (s_valid && sv < 40) begin sv++; tick(); end
      checks++;
      if ({m1_ready, m1_rdata, error, sv} !== {1'b1, exp_rd, 1'b0, 32'd8}) begin
         failures++; $display("FAIL race_resp got rdy=%b d=%h err=%b cyc=%0d exp rdy=1 d=%h err=0 cyc=8", m1_ready, m1_rdata, error, sv, exp_rd);
      end
      m1_valid = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_timeout;
      int          sv;
      bit          seen;
      logic [31:0] exp_rd;
      sv = 0;
      seen = 1'b0;
      pulse_reset();
      slv_never = 1'b1;
      m0_valid = 1'b1; m0_addr = $urandom; m0_wstrb = 4'h0;
      tick();
      while (s_valid && sv < 40) begin sv++; tick(); end
      checks++;
      if ({m0_ready, m0_rdata, error, sv} !== {1'b1, 32'hdeadbeef, 1'b1, 32'd8}) begin
         failures++; $display("FAIL timeout_resp got rdy=%b d=%h err=%b cyc=%0d exp rdy=1 d=deadbeef err=1 cyc=8", m0_ready, m0_rdata, error, sv);
      end
      m0_valid  = 1'b0;
      slv_never = 1'b0;
      slv_wait  = 1;
      slv_rdata = $urandom;
      exp_rd    = slv_rdata;
      repeat (2) tick();
      m0_valid = 1'b1; m0_addr = $urandom;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         seen = m0_ready;
      end
      checks++;
      if ({seen, m0_rdata, error} !== {1'b1, exp_rd, 1'b1}) begin
         failures++; $display("FAIL timeout_followup got rdy=%b d=%h err=%b exp rdy=1 d=%h err=1", seen, m0_rdata, error, exp_rd);
      end
      m0_valid = 1'b0;
      repeat (2) tick();
   endtask
`endif

   task automatic test_async_reset;
      bit seen;
      seen = 1'b0;
      slv_never = 1'b1;
      m1_valid = 1'b1; m1_addr = 32'h43000010; m1_wstrb = 4'h0;
      tick();
      checks++;
      if ({s_valid, s_addr} !== {1'b1, 32'h43000010}) begin
         failures++; $display("FAIL areset_grant got v=%b a=%h exp v=1 a=43000010", s_valid, s_addr);
      end
      tick();
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({s_valid, m1_ready, error, s_addr} !== 35'h0) begin
         failures++; $display("FAIL areset_abort got v=%b r1=%b err=%b a=%h exp all 0", s_valid, m1_ready, error, s_addr);
      end
      m1_valid  = 1'b0;
      slv_never = 1'b0;
      slv_wait  = 0;
      #2;
      reset_n = 1'b1;
      tick();
      m0_valid = 1'b1; m0_addr = 32'h10000abc;
      m1_valid = 1'b1; m1_addr = 32'h20000abc;
      tick();
      checks++;
      if ({s_valid, s_addr} !== {1'b1, 32'h10000abc}) begin
         failures++; $display("FAIL areset_tie got v=%b a=%h exp v=1 a=10000abc", s_valid, s_addr);
      end
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         if (m0_ready) m0_valid = 1'b0;
         seen = m1_ready;
      end
      m1_valid = 1'b0;
      checks++;
      if (seen !== 1'b1) begin failures++; $display("FAIL areset_second got no m1_ready"); end
      repeat (2) tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_contention();
      test_write_wait();
      test_random();
`ifdef MEM_ARBITER_TIMEOUT_EN
      test_timeout_race();
      test_timeout();
`endif
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
